mem_block_mover: RTL
====================

// Module: mem_block_mover
// PURPOSE
//  Initiator side of the single-port data memory interface (8-bit word address, 32-bit data,
//  combinational read, write on posedge clk when data_mem_write=1).
//  Copies LEN consecutive words from SRC to DST: read one word, write one word, repeat.
//  Sits beside the CPU datapath; the CPU-side mux hands it the data port while busy=1.
// PARAMETERS
//  ADDR_W     8   word address width; addresses wrap modulo 2**ADDR_W
//  WORD_SIZE  32  data word width
//  LEN_W      9   transfer length width; legal lengths are 0..2**ADDR_W
// PORTS
//  clk              in   1          single clock, all state on posedge
//  rst              in   1          asynchronous, active-low reset
//  start            in   1          request pulse, sampled only in IDLE
//  src_addr         in   ADDR_W     first source word address
//  dst_addr         in   ADDR_W     first destination word address
//  len              in   LEN_W      number of words to copy
//  busy             out  1          1 whenever state != IDLE
//  done             out  1          1-cycle pulse at completion
//  data_mem_write   out  1          memory write enable
//  data_address     out  ADDR_W     memory word address
//  data_write_data  out  WORD_SIZE  memory write data
//  data_read_data   in   WORD_SIZE  memory read data, combinational from data_address
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, busy=0, done=0, data_mem_write=0, data_address=0,
//    data_write_data=0, idx=0, hold=0. Write enable drops immediately. A partial copy stays in memory.
//  - FSM states: IDLE, READ, WRITE, DONE. All outputs decode from registers (Moore).
//  - IDLE: outputs at their reset values. If start=1, latch src_addr, dst_addr and len, set idx=0.
//    Next state is READ if len!=0, else DONE. start=0 stays in IDLE.
//  - READ: data_address=src+idx, data_mem_write=0. Capture data_read_data into hold on the edge.
//    Next state is WRITE.
//  - WRITE: data_address=dst+idx, data_write_data=hold, data_mem_write=1.
//    If idx==len-1, next state is DONE; else idx++ and next state is READ.
//  - DONE: done=1, busy=1, data_mem_write=0. Next state is IDLE.
//  - Timing: start is sampled on edge E0. Word k is read in cycle 2k+1 and written at the end of cycle 2k+2.
//    done is high in cycle 2N+1 (N=len); len=0 gives done in cycle 1 with no writes.
//    busy is low again in cycle 2N+2.
//  - Address arithmetic is ADDR_W bits, modulo 2**ADDR_W. src+idx and dst+idx wrap from 255 to 0.
//  - len > 2**ADDR_W: only the low LEN_W bits are used. No clamping.
//  - start while busy (READ, WRITE or DONE): ignored. No queueing.
//  - start asserted in the DONE cycle is ignored. A new transfer needs start high in an IDLE cycle.
//  - Overlapping regions are copied in ascending word order, word by word.
//    If dst is in (src, src+len), already-overwritten words are re-read; this is the defined behaviour.
//  - src==dst: each word is rewritten with its own value. Timing is unchanged.
//  - Input changes during a transfer have no effect, because all inputs are latched in IDLE.
// CONFIGURATION
//  MEM_MOVER_CHECKSUM_EN defined:
//    - Extra output checksum [WORD_SIZE-1:0], reset 0, cleared when start is accepted.
//    - Each WRITE cycle adds hold to checksum, 32-bit wraparound sum.
//    - checksum is stable from the DONE cycle until the next accepted start.
//    - len=0 gives checksum=0.
//  MEM_MOVER_CHECKSUM_EN undefined: the port and adder do not exist. All other behaviour is identical.
// TESTING (bench wraps the 256x32 memory model; memory preloaded with mem[i]=i*3+1)
//  1. src=8, dst=100, len=4, start at E0.
//     -> writes at ends of cycles 2,4,6,8: mem[100..103]=25,28,31,34. done in cycle 9. busy low in cycle 10.
//  2. len=0 -> done=1 in cycle 1, no data_mem_write pulse, memory unchanged. With CHECKSUM_EN, checksum=0.
//  3. src=254, dst=0, len=3 -> reads addresses 254,255,0. mem[0]=763, mem[1]=766, then mem[2]=763.
//     The third word is mem[0] re-read after its overwrite.
//  4. start pulsed again in cycles 3 and 9 of scenario 1 -> ignored. Only 4 writes occur. State is IDLE at cycle 10.
//  5. rst low mid-way through cycle 4 of scenario 1 -> data_mem_write=0 and busy=0 immediately.
//     mem[100]=25 is written, mem[101..] are unchanged. A new start after reset runs normally.
//  6. CHECKSUM_EN, scenario 1 -> checksum=118 (25+28+31+34) in cycle 9.
//     checksum is held until the next start, then cleared.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Data-memory port between the block mover (master) and the single-port
// data memory (slave). Read data is combinational from data_address; the
// memory writes on posedge clk while data_mem_write is high.
interface mem_block_mover_if #(
  parameter int ADDR_W    = 8,
  parameter int WORD_SIZE = 32
);
  logic                 data_mem_write;
  logic [ADDR_W-1:0]    data_address;
  logic [WORD_SIZE-1:0] data_write_data;
  logic [WORD_SIZE-1:0] data_read_data;

  modport master (
    output data_mem_write,
    output data_address,
    output data_write_data,
    input  data_read_data
  );

  modport slave (
    input  data_mem_write,
    input  data_address,
    input  data_write_data,
    output data_read_data
  );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies len consecutive words from src_addr to dst_addr,
// one read cycle followed by one write cycle per word, in ascending order.
// Addresses wrap modulo 2**ADDR_W. All inputs are latched when start is
// accepted in IDLE; start is ignored at any other time.
// Optional feature: define MEM_MOVER_CHECKSUM_EN to add a 32-bit wraparound
// sum of all written words on the checksum output.
module mem_block_mover #(
  parameter int ADDR_W    = 8,
  parameter int WORD_SIZE = 32,
  parameter int LEN_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
`ifdef MEM_MOVER_CHECKSUM_EN
  output logic [WORD_SIZE-1:0] checksum,
`endif
  mem_block_mover_if.master    mem
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t               state, state_nx;
  logic [ADDR_W-1:0]    src_q, dst_q;
  logic [LEN_W-1:0]     len_q, idx;
  logic [WORD_SIZE-1:0] hold;
  logic                 last;

  // idx addresses the word currently in flight; the last word ends the copy
  assign last = (idx == len_q - LEN_W'(1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len != '0) ? S_READ : S_DONE;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = last ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // request latch, word index and read-data holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          len_q <= len;
          idx   <= '0;
        end
        S_READ:  hold <= mem.data_read_data;
        S_WRITE: if (!last) idx <= idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // Moore outputs: everything decodes from state and registers, so an
  // asynchronous reset drops the write enable immediately
  always_comb begin
    busy                = (state != S_IDLE);
    done                = (state == S_DONE);
    mem.data_mem_write  = 1'b0;
    mem.data_address    = '0;
    mem.data_write_data = '0;
    case (state)
      S_READ:  mem.data_address = src_q + idx[ADDR_W-1:0];
      S_WRITE: begin
        mem.data_address    = dst_q + idx[ADDR_W-1:0];
        mem.data_write_data = hold;
        mem.data_mem_write  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_MOVER_CHECKSUM_EN
  // running sum of written words; cleared on an accepted start, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_WRITE)         checksum <= checksum + hold;
  end
`endif

endmodule
